// File: rtl/hazard_pkg.sv
// hazard_pkg
//   Definitions shared by the hazard controller and the control unit:
//   forwarding-select encodings, the "operand not read" Tuse marker,
//   the pipeline stage record and its small helper functions.
package hazard_pkg;

  // Field widths of a stage record.
  localparam int REG_W  = 5;  // register-address width
  localparam int TNEW_W = 2;  // Tuse/Tnew width

  // Forwarding source selects (shared by the D and E stage muxes).
  localparam logic [1:0] FWD_RF = 2'd0;  // register file / ID-EX value
  localparam logic [1:0] FWD_W  = 2'd1;  // W stage result
  localparam logic [1:0] FWD_M  = 2'd2;  // M stage result
  localparam logic [1:0] FWD_E  = 2'd3;  // E stage result (D operands only)

  // Tuse value meaning the operand is not read at all.
  localparam logic [TNEW_W-1:0] TUSE_NONE = 2'd3;

  // One pipeline stage as seen by the hazard logic.
  typedef struct packed {
    logic [REG_W-1:0]  a3;    // destination register
    logic [TNEW_W-1:0] tnew;  // cycles until the result is forwardable
    logic              wr;    // instruction writes the register file
    logic [REG_W-1:0]  rs;    // source register rs
    logic [REG_W-1:0]  rt;    // source register rt
  } stage_rec_t;

  // Decrement with a floor of zero.
  function automatic logic [TNEW_W-1:0] sat_dec(input logic [TNEW_W-1:0] t);
    return (t == '0) ? '0 : t - 1'b1;
  endfunction

  // A write to $0 is discarded by the register file, so it never counts.
  function automatic logic eff_write(input stage_rec_t r);
    return r.wr && (r.a3 != '0);
  endfunction

endpackage

// File: rtl/hazard_stage_reg.sv
// hazard_stage_reg
//   One pipeline stage record register.
//   Ports:
//     clk     in   system clock, rising edge
//     reset   in   asynchronous active-high reset, clears the record
//     clear   in   load a bubble (all-zero record) instead of rec_in
//     rec_in  in   record from the previous stage
//     rec_out out  registered record of this stage
//   DEC_TNEW selects whether tnew is decremented (saturating) on the way in.
module hazard_stage_reg
  import hazard_pkg::*;
#(
  parameter bit DEC_TNEW = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  stage_rec_t rec_in,
  output stage_rec_t rec_out
);

  stage_rec_t rec_d;
  stage_rec_t rec_q;

  always_comb begin
    rec_d = rec_in;
    if (DEC_TNEW) begin
      rec_d.tnew = sat_dec(rec_in.tnew);
    end
    if (clear) begin
      rec_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rec_q <= '0;
    end else begin
      rec_q <= rec_d;
    end
  end

  assign rec_out = rec_q;

endmodule

// File: rtl/hazard_unit.sv
// hazard_unit
//   Stall and forwarding controller for the 5-stage MIPS pipeline.
//   Tracks {a3, tnew, wr, rs, rt} for the E, M and W stages and compares
//   them against the D-stage operands and Tuse values.
//   Ports:
//     clk, reset          clock (rising edge), async active-high reset
//     rs_D, rt_D, a3_D    D-stage source and destination addresses
//     regwrite_D          D-stage instruction writes the register file
//     tuse_rs_D/tuse_rt_D cycles until rs/rt are needed (3 = unused)
//     tnew_D              cycles after entering E until result is ready
//     stall               freeze PC and IF/ID, bubble into ID/EX
//     fwd_rs_D/fwd_rt_D   D operand source: 0 RF, 1 W, 2 M, 3 E
//     fwd_rs_E/fwd_rt_E   E operand source: 0 ID/EX, 1 W, 2 M
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int NREG_BITS = REG_W,
  parameter int T_BITS    = TNEW_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREG_BITS-1:0] rs_D,
  input  logic [NREG_BITS-1:0] rt_D,
  input  logic [NREG_BITS-1:0] a3_D,
  input  logic                 regwrite_D,
  input  logic [T_BITS-1:0]    tuse_rs_D,
  input  logic [T_BITS-1:0]    tuse_rt_D,
  input  logic [T_BITS-1:0]    tnew_D,
  output logic                 stall,
  output logic [1:0]           fwd_rs_D,
  output logic [1:0]           fwd_rt_D,
  output logic [1:0]           fwd_rs_E,
  output logic [1:0]           fwd_rt_E
);

  // rec[0] is the D stage (combinational), rec[1..3] are E, M, W.
  stage_rec_t rec [4];
  stage_rec_t rec_e;
  stage_rec_t rec_m;
  stage_rec_t rec_w;
  logic       stall_rs;
  logic       stall_rt;

  assign rec[0] = '{a3: a3_D, tnew: tnew_D, wr: regwrite_D, rs: rs_D, rt: rt_D};

  // E takes tnew straight from D; M and W age it by one each cycle.
  // Only the E register is bubbled on stall; M and W keep draining.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_stage
      hazard_stage_reg #(
        .DEC_TNEW(gi != 0)
      ) u_stage (
        .clk    (clk),
        .reset  (reset),
        .clear  ((gi == 0) ? stall : 1'b0),
        .rec_in (rec[gi]),
        .rec_out(rec[gi+1])
      );
    end
  endgenerate

  assign rec_e = rec[1];
  assign rec_m = rec[2];
  assign rec_w = rec[3];

  // A producer blocks the operand if its result will not be ready by the
  // time the operand is consumed (tuse < tnew).
  function automatic logic op_stall(input logic [REG_W-1:0]  addr,
                                    input logic [TNEW_W-1:0] tuse,
                                    input stage_rec_t        e,
                                    input stage_rec_t        m);
    logic hit_e;
    logic hit_m;
    hit_e = eff_write(e) && (e.a3 == addr) && (tuse < e.tnew);
    hit_m = eff_write(m) && (m.a3 == addr) && (tuse < m.tnew);
    return (tuse != TUSE_NONE) && (addr != '0) && (hit_e || hit_m);
  endfunction

  // A stage can forward only once its result exists (tnew == 0).
  function automatic logic fwd_hit(input logic [REG_W-1:0] addr,
                                   input stage_rec_t       r);
    return eff_write(r) && (r.a3 == addr) && (r.tnew == '0);
  endfunction

  // Youngest producer wins: E over M over W.
  function automatic logic [1:0] fwd_sel_d(input logic [REG_W-1:0] addr,
                                           input stage_rec_t       e,
                                           input stage_rec_t       m,
                                           input stage_rec_t       w);
    if (fwd_hit(addr, e)) return FWD_E;
    if (fwd_hit(addr, m)) return FWD_M;
    if (fwd_hit(addr, w)) return FWD_W;
    return FWD_RF;
  endfunction

  function automatic logic [1:0] fwd_sel_e(input logic [REG_W-1:0] addr,
                                           input stage_rec_t       m,
                                           input stage_rec_t       w);
    if (fwd_hit(addr, m)) return FWD_M;
    if (fwd_hit(addr, w)) return FWD_W;
    return FWD_RF;
  endfunction

  always_comb begin
    stall_rs = op_stall(rs_D, tuse_rs_D, rec_e, rec_m);
    stall_rt = op_stall(rt_D, tuse_rt_D, rec_e, rec_m);
    stall    = stall_rs || stall_rt;

    // Selects are produced even while stalling; the bubble makes them moot.
    fwd_rs_D = fwd_sel_d(rs_D, rec_e, rec_m, rec_w);
    fwd_rt_D = fwd_sel_d(rt_D, rec_e, rec_m, rec_w);
    fwd_rs_E = fwd_sel_e(rec_e.rs, rec_m, rec_w);
    fwd_rt_E = fwd_sel_e(rec_e.rt, rec_m, rec_w);
  end

endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit
//   Directed-vector bench for hazard_unit: load-use, load-branch,
//   ALU-branch, $0 / unused operands, forwarding priority and an
//   asynchronous reset during a stall.
module tb_hazard_unit;

  logic       clk;
  logic       reset;
  logic [4:0] rs_D;
  logic [4:0] rt_D;
  logic [4:0] a3_D;
  logic       regwrite_D;
  logic [1:0] tuse_rs_D;
  logic [1:0] tuse_rt_D;
  logic [1:0] tnew_D;
  logic       stall;
  logic [1:0] fwd_rs_D;
  logic [1:0] fwd_rt_D;
  logic [1:0] fwd_rs_E;
  logic [1:0] fwd_rt_E;

  int n_checks;
  int n_passed;

  hazard_unit dut (
    .clk       (clk),
    .reset     (reset),
    .rs_D      (rs_D),
    .rt_D      (rt_D),
    .a3_D      (a3_D),
    .regwrite_D(regwrite_D),
    .tuse_rs_D (tuse_rs_D),
    .tuse_rt_D (tuse_rt_D),
    .tnew_D    (tnew_D),
    .stall     (stall),
    .fwd_rs_D  (fwd_rs_D),
    .fwd_rt_D  (fwd_rt_D),
    .fwd_rs_E  (fwd_rs_E),
    .fwd_rt_E  (fwd_rt_E)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) begin
      n_passed++;
      $display("ok   %-22s got %0d", tag, obs);
    end else begin
      $display("FAIL %-22s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present a D-stage instruction.
  task automatic drive(input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] a3, input logic wr,
                       input logic [1:0] trs, input logic [1:0] trt,
                       input logic [1:0] tn);
    rs_D       = rs;
    rt_D       = rt;
    a3_D       = a3;
    regwrite_D = wr;
    tuse_rs_D  = trs;
    tuse_rt_D  = trt;
    tnew_D     = tn;
    #1;
  endtask

  task automatic nop();
    drive(5'd0, 5'd0, 5'd0, 1'b0, 2'd3, 2'd3, 2'd0);
  endtask

  // Advance one rising edge; inputs are then changed 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_passed = 0;
    reset    = 1'b1;
    nop();
    #12;
    check("rst_stall", int'(stall), 0);
    check("rst_fwd_rs_D", int'(fwd_rs_D), 0);
    check("rst_fwd_rt_D", int'(fwd_rt_D), 0);
    check("rst_fwd_rs_E", int'(fwd_rs_E), 0);
    check("rst_fwd_rt_E", int'(fwd_rt_E), 0);
    reset = 1'b0;

    // Load-use: lw $8 then add rs=$8 (tuse 1).
    tick();
    drive(5'd0, 5'd0, 5'd8, 1'b1, 2'd3, 2'd3, 2'd2);
    check("lu_lw_nostall", int'(stall), 0);
    tick();
    drive(5'd8, 5'd0, 5'd0, 1'b0, 2'd1, 2'd1, 2'd1);
    check("lu_stall_c1", int'(stall), 1);
    tick();
    check("lu_stall_c2", int'(stall), 0);
    check("lu_fwd_rs_D_c2", int'(fwd_rs_D), 0);
    tick();
    nop();
    check("lu_fwd_rs_E_W", int'(fwd_rs_E), 1);
    check("lu_fwd_rt_E", int'(fwd_rt_E), 0);

    // Load-branch: lw $9 then beq rs=$9 (tuse 0).
    tick();
    drive(5'd0, 5'd0, 5'd9, 1'b1, 2'd3, 2'd3, 2'd2);
    tick();
    drive(5'd9, 5'd0, 5'd0, 1'b0, 2'd0, 2'd0, 2'd0);
    check("lb_stall_c1", int'(stall), 1);
    tick();
    check("lb_stall_c2", int'(stall), 1);
    tick();
    check("lb_stall_c3", int'(stall), 0);
    check("lb_fwd_rs_D_W", int'(fwd_rs_D), 1);

    // ALU-branch: addu $10 then beq rt=$10 (tuse 0).
    tick();
    drive(5'd0, 5'd0, 5'd10, 1'b1, 2'd3, 2'd3, 2'd1);
    tick();
    drive(5'd0, 5'd10, 5'd0, 1'b0, 2'd0, 2'd0, 2'd0);
    check("ab_stall_c1", int'(stall), 1);
    tick();
    check("ab_stall_c2", int'(stall), 0);
    check("ab_fwd_rt_D_M", int'(fwd_rt_D), 2);
    check("ab_fwd_rs_D", int'(fwd_rs_D), 0);

    // Drain, then $0 writer with tnew 0 must not forward or stall.
    tick(); nop();
    tick(); nop();
    tick();
    drive(5'd0, 5'd0, 5'd0, 1'b1, 2'd3, 2'd3, 2'd0);
    tick();
    drive(5'd0, 5'd0, 5'd0, 1'b0, 2'd0, 2'd0, 2'd0);
    check("z0_stall", int'(stall), 0);
    check("z0_fwd_rs_D", int'(fwd_rs_D), 0);
    check("z0_fwd_rt_D", int'(fwd_rt_D), 0);
    // Unused operands matching an in-flight load.
    tick();
    drive(5'd0, 5'd0, 5'd12, 1'b1, 2'd3, 2'd3, 2'd2);
    tick();
    drive(5'd12, 5'd12, 5'd0, 1'b0, 2'd3, 2'd3, 2'd0);
    check("unused_stall", int'(stall), 0);

    // Priority: three consecutive $5 writers with tnew 0 (they read $5 too).
    tick();
    drive(5'd5, 5'd5, 5'd5, 1'b1, 2'd1, 2'd1, 2'd0);
    tick();
    tick();
    tick();
    drive(5'd5, 5'd0, 5'd0, 1'b0, 2'd0, 2'd3, 2'd0);
    check("pr_stall", int'(stall), 0);
    check("pr_fwd_rs_D_E", int'(fwd_rs_D), 3);
    check("pr_fwd_rs_E_M", int'(fwd_rs_E), 2);
    check("pr_fwd_rt_E_M", int'(fwd_rt_E), 2);
    tick();
    nop();
    drive(5'd5, 5'd0, 5'd0, 1'b0, 2'd0, 2'd3, 2'd0);
    check("pr_fwd_rs_D_M", int'(fwd_rs_D), 2);
    tick();
    nop();
    drive(5'd0, 5'd5, 5'd0, 1'b0, 2'd3, 2'd0, 2'd0);
    check("pr_fwd_rt_D_W", int'(fwd_rt_D), 1);

    // Async reset in the middle of a stall cycle.
    tick();
    drive(5'd0, 5'd0, 5'd8, 1'b1, 2'd3, 2'd3, 2'd2);
    tick();
    drive(5'd8, 5'd0, 5'd0, 1'b0, 2'd0, 2'd3, 2'd0);
    check("ar_stall_before", int'(stall), 1);
    #1 reset = 1'b1;
    #1;
    check("ar_stall_now", int'(stall), 0);
    check("ar_fwd_rs_D", int'(fwd_rs_D), 0);
    check("ar_fwd_rs_E", int'(fwd_rs_E), 0);
    tick();
    #2 reset = 1'b0;
    #1;
    check("ar_stall_after", int'(stall), 0);
    tick();
    check("ar_stall_post_edge", int'(stall), 0);
    check("ar_fwd_rs_D_post", int'(fwd_rs_D), 0);

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #20000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
